axi_sdram_aw_chn: RTL
=====================

# axi_sdram_aw_chn

AXI write-address channel front end for the AXI-SDRAM bridge. It accepts INCR write bursts on AW, splits each burst at SDRAM row boundaries into one or more row-contained write commands, and pushes the burst's byte offset (awaddr[1:0]) into the write-burst unaligned-address message FIFO. That FIFO is the one the W/B channel stage reads to mask the first beat's keep and to pace write responses. The block sits between the AXI slave port and the SDRAM controller's write-command input, in parallel with the W/B channel stage.

## Interface
Parameters:
- COL_ADDR_W, default 8: column (32-bit word) address width per SDRAM row; a row holds 2^COL_ADDR_W words. Legal range 1..12.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_axi_awaddr  in  32  burst start byte address
- s_axi_awlen  in  8  beats-1
- s_axi_awsize  in  3  expected 3'b010
- s_axi_awburst  in  2  expected 2'b01 (INCR)
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- m_wcmd_addr  out  32  command start byte address, bits[1:0] always 0
- m_wcmd_len  out  8  command beats-1
- m_wcmd_valid  out  1  command valid
- m_wcmd_ready  in  1  command ready
- wt_burst_unaligned_msg_fifo_wen  out  1  FIFO write strobe
- wt_burst_unaligned_msg_fifo_din  out  2  awaddr[1:0] of accepted burst
- wt_burst_unaligned_msg_fifo_full_n  in  1  FIFO not full
- aw_err  out  1  sticky illegal-AW flag (see Configuration)

## Operation
- FSM states: IDLE, CMD.
- IDLE: s_axi_awready = ~rst & wt_burst_unaligned_msg_fifo_full_n. On AW handshake:
  - latch word_addr = awaddr[31:2] and remain = awlen+1 (9 bits, 1..256);
  - assert fifo_wen for that same cycle, with din = awaddr[1:0] (combinational from the AW inputs);
  - go to CMD.
- CMD: s_axi_awready = 0.
  - col_room = 2^COL_ADDR_W - word_addr[COL_ADDR_W-1:0], computed at ≥10-bit width.
  - chunk = min(remain, col_room).
  - Present m_wcmd_addr = {word_addr, 2'b00}, m_wcmd_len = chunk-1.
  - On command handshake: word_addr += chunk, remain -= chunk. If remain == chunk, go to IDLE; otherwise stay in CMD.
- Address arithmetic wraps modulo 2^30 words; no 4 KB or bank checks.
- awsize and awburst are not used by the datapath. All bursts are treated as 32-bit INCR.
- Exactly one FIFO entry is written per accepted AW, regardless of how many commands the burst is split into.

## Timing
- Reset values: s_axi_awready 0 (while rst is high), m_wcmd_valid 0, m_wcmd_addr 0, m_wcmd_len 0, fifo_wen 0, fifo_din 0, aw_err 0; FSM in IDLE.
- m_wcmd_valid, m_wcmd_addr and m_wcmd_len are registered.
  - The first command of a burst is valid on the cycle after the AW handshake.
  - Subsequent split commands are valid on the cycle after the previous command's handshake.
  - While valid and not ready, the command outputs are held stable.
- After the last command's handshake, the FSM is in IDLE on the next cycle. AW-to-AW spacing is therefore at least (number of commands + 1) cycles.
- If fifo_full_n is low in IDLE, awready is 0 and fifo_wen is 0. fifo_full_n has no effect in CMD.
- Asserting rst mid-burst:
  - discards the remaining commands;
  - clears m_wcmd_valid on the next edge;
  - does not touch FIFO contents (the FIFO has its own reset).
- m_wcmd_ready asserted while m_wcmd_valid is 0 is ignored.

## Configuration
- Macro AXI_SDRAM_AW_CHK_EN.
- Defined: on each AW handshake, if awsize != 3'b010 or awburst != 2'b01, aw_err is set one cycle later and stays set until rst. The burst is still processed normally.
- Undefined: aw_err is tied to 0 and no check logic is built.

## Test plan
- Aligned burst, awaddr 0x0000_0100, awlen 15, COL_ADDR_W 8 -> one fifo_wen with din 2'b00 in the handshake cycle; one command, addr 0x100, len 15, valid the next cycle.
- Row crossing, awaddr 0x0000_03F8 (word 0xFE), awlen 3 -> commands (0x3F8, len 1) then (0x400, len 1); exactly one fifo_wen.
- Unaligned, awaddr 0x0000_0103, awlen 0 -> din 2'b11; command addr 0x100, len 0.
- Max burst at row start, awaddr 0x0000_0400, awlen 255 -> one command, addr 0x400, len 255; with COL_ADDR_W 6, four commands of len 63 at 0x400, 0x500, 0x600, 0x700.
- Backpressure: hold fifo_full_n at 0 for 4 cycles -> awready 0 and no fifo_wen. Then hold m_wcmd_ready at 0 for 5 cycles -> command outputs stable; awready stays 0 until one cycle after the handshake.
- Reset in CMD after the first of two split commands -> m_wcmd_valid 0 after the edge and no second command. With AXI_SDRAM_AW_CHK_EN defined, awsize 3'b001 sets aw_err, which stays 1 until rst.

Source files
------------

// File: rtl/axi_sdram_aw_chn.sv
// ============================================================================
// Module   : axi_sdram_aw_chn
// Summary  : AXI write-address front end. It splits INCR bursts at SDRAM row
//            boundaries into write commands and posts each burst's byte
//            offset to the unaligned-address message FIFO.
//            Optional AW legality check: define AXI_SDRAM_AW_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_sdram_aw_chn #(
    parameter int COL_ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    output logic [31:0] m_wcmd_addr,
    output logic [7:0]  m_wcmd_len,
    output logic        m_wcmd_valid,
    input  logic        m_wcmd_ready,
    output logic        wt_burst_unaligned_msg_fifo_wen,
    output logic [1:0]  wt_burst_unaligned_msg_fifo_din,
    input  logic        wt_burst_unaligned_msg_fifo_full_n,
    output logic        aw_err
);

    localparam logic [12:0] c_ROW_WORDS = 13'(1 << COL_ADDR_W);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CMD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] word_addr_q, word_addr_d;
    logic [8:0]  remain_q, remain_d;
    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;

    logic        w_aw_hs;
    logic        w_cmd_hs;
    logic [8:0]  w_cur_chunk;
    logic [29:0] w_nxt_word;
    logic [8:0]  w_nxt_remain;
    logic [12:0] w_nxt_room;
    logic [8:0]  w_nxt_chunk;
    logic [8:0]  w_nxt_len9;

    assign s_axi_awready = (state_q == S_IDLE) & ~rst & wt_burst_unaligned_msg_fifo_full_n;
    assign w_aw_hs       = s_axi_awvalid & s_axi_awready;
    assign w_cmd_hs      = valid_q & m_wcmd_ready;
    assign w_cur_chunk   = {1'b0, len_q} + 9'd1;

    assign wt_burst_unaligned_msg_fifo_wen = w_aw_hs;
    assign wt_burst_unaligned_msg_fifo_din = w_aw_hs ? s_axi_awaddr[1:0] : 2'b00;

    assign m_wcmd_valid = valid_q;
    assign m_wcmd_addr  = addr_q;
    assign m_wcmd_len   = len_q;

    // Next command is derived from either a fresh burst or the one just accepted,
    // so the command registers always hold the command being presented.
    always_comb begin
        w_nxt_word   = word_addr_q;
        w_nxt_remain = remain_q;
        if (state_q == S_IDLE) begin
            w_nxt_word   = s_axi_awaddr[31:2];
            w_nxt_remain = {1'b0, s_axi_awlen} + 9'd1;
        end else begin
            w_nxt_word   = word_addr_q + {21'd0, w_cur_chunk};
            w_nxt_remain = remain_q - w_cur_chunk;
        end
        w_nxt_room  = c_ROW_WORDS - {{(13-COL_ADDR_W){1'b0}}, w_nxt_word[COL_ADDR_W-1:0]};
        w_nxt_chunk = ({4'd0, w_nxt_remain} <= w_nxt_room) ? w_nxt_remain : w_nxt_room[8:0];
        w_nxt_len9  = w_nxt_chunk - 9'd1;
    end

    always_comb begin
        state_d     = state_q;
        word_addr_d = word_addr_q;
        remain_d    = remain_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        len_d       = len_q;
        case (state_q)
            S_IDLE: begin
                if (w_aw_hs) begin
                    state_d     = S_CMD;
                    word_addr_d = w_nxt_word;
                    remain_d    = w_nxt_remain;
                    valid_d     = 1'b1;
                    addr_d      = {w_nxt_word, 2'b00};
                    len_d       = w_nxt_len9[7:0];
                end
            end
            S_CMD: begin
                if (w_cmd_hs) begin
                    if (remain_q == w_cur_chunk) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                    end else begin
                        word_addr_d = w_nxt_word;
                        remain_d    = w_nxt_remain;
                        addr_d      = {w_nxt_word, 2'b00};
                        len_d       = w_nxt_len9[7:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            word_addr_q <= 30'd0;
            remain_q    <= 9'd0;
            valid_q     <= 1'b0;
            addr_q      <= 32'd0;
            len_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            word_addr_q <= word_addr_d;
            remain_q    <= remain_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
        end
    end

`ifdef AXI_SDRAM_AW_CHK_EN
    logic aw_err_q;
    logic w_unused;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_err_q <= 1'b0;
        end else if (w_aw_hs && ((s_axi_awsize != 3'b010) || (s_axi_awburst != 2'b01))) begin
            aw_err_q <= 1'b1;
        end
    end

    assign aw_err   = aw_err_q;
    assign w_unused = w_nxt_len9[8];
`else
    logic w_unused;

    assign aw_err   = 1'b0;
    assign w_unused = ^{s_axi_awsize, s_axi_awburst, w_nxt_len9[8]};
`endif

endmodule

`default_nettype wire
